// File: rtl/io_timer_pkg.sv
// Shared constants for the bank-5 programmable timer: register offsets,
// CTRL/STATUS bit positions and the IO bank number used by the decoder.
package io_timer_pkg;

  localparam logic [7:0] IO_BANK_TIMER = 8'h05;

  localparam logic [2:0] TMR_CTRL      = 3'd0;
  localparam logic [2:0] TMR_STATUS    = 3'd1;
  localparam logic [2:0] TMR_PRESC_LO  = 3'd2;
  localparam logic [2:0] TMR_PRESC_HI  = 3'd3;
  localparam logic [2:0] TMR_RELOAD_LO = 3'd4;
  localparam logic [2:0] TMR_RELOAD_HI = 3'd5;
  localparam logic [2:0] TMR_COUNT_LO  = 3'd6;
  localparam logic [2:0] TMR_COUNT_HI  = 3'd7;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;

  localparam int STAT_EXP = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: emits a one-cycle tick every div+1 enabled clocks.
// clr restarts the division from zero and takes priority over counting.
module timer_prescaler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = en & (cnt == div);

  // Count up to div, then wrap to zero; hold while disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= 16'd0;
    end else if (en) begin
      if (cnt == div) cnt <= 16'd0;
      else            cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// 16-bit down-counting timer with prescaler, reload, one-shot/periodic
// modes, sticky expiry flag, level interrupt and tear-free count reads.
module io_timer
  import io_timer_pkg::*;
#(
  parameter int CLK_HZ = 27000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_i,
  input  logic       R_W_n,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_o
);

  // Clock rate is documentation for software; upper address bits alias.
  localparam int unused_clk_hz = CLK_HZ;
  logic unused_addr;
  assign unused_addr = ^addr_i[7:3];

  logic [2:0]  off;
  logic        wr_en, rd_en;
  logic        ctrl_en, ctrl_per, ctrl_ie;
  logic        exp_q, irq_q;
  logic [15:0] presc_div, reload, count;
  logic [7:0]  wr_lo, snap;
  logic        tick, ctrl_wr, en_start, cnt_load, expire, stat_clr;

  assign off      = addr_i[2:0];
  assign wr_en    = cs_i & ~R_W_n;
  assign rd_en    = cs_i & R_W_n;
  assign ctrl_wr  = wr_en & (off == TMR_CTRL);
  assign en_start = ctrl_wr & data_i[CTRL_EN] & ~ctrl_en;
  assign cnt_load = wr_en & (off == TMR_COUNT_HI);
  assign stat_clr = wr_en & (off == TMR_STATUS) & data_i[STAT_EXP];
  // A count load or restart swallows a coincident tick, so no expiry then.
  assign expire   = ctrl_en & tick & (count == 16'd0) & ~cnt_load & ~en_start;

  timer_prescaler u_presc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ctrl_en),
    .clr   (cnt_load | en_start),
    .div   (presc_div),
    .tick  (tick)
  );

  // Plain CPU-writable registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_per  <= 1'b0;
      ctrl_ie   <= 1'b0;
      presc_div <= 16'd0;
      reload    <= 16'd0;
      wr_lo     <= 8'd0;
    end else if (wr_en) begin
      case (off)
        TMR_CTRL: begin
          ctrl_per <= data_i[CTRL_PERIODIC];
          ctrl_ie  <= data_i[CTRL_IE];
        end
        TMR_PRESC_LO:  presc_div[7:0]  <= data_i;
        TMR_PRESC_HI:  presc_div[15:8] <= data_i;
        TMR_RELOAD_LO: reload[7:0]     <= data_i;
        TMR_RELOAD_HI: reload[15:8]    <= data_i;
        TMR_COUNT_LO:  wr_lo           <= data_i;
        default: ;
      endcase
    end
  end

  // EN follows CTRL writes; a one-shot expiry drops it on its own.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    ctrl_en <= 1'b0;
    else if (ctrl_wr)             ctrl_en <= data_i[CTRL_EN];
    else if (expire && !ctrl_per) ctrl_en <= 1'b0;
  end

  // Down-counter: explicit load beats restart beats tick processing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= 16'd0;
    end else if (cnt_load) begin
      count <= {data_i, wr_lo};
    end else if (en_start) begin
      count <= reload;
    end else if (ctrl_en && tick) begin
      if (count != 16'd0) count <= count - 16'd1;
      else if (ctrl_per)  count <= reload;
    end
  end

  // Sticky expiry flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i)         exp_q <= 1'b0;
    else if (expire)   exp_q <= 1'b1;
    else if (stat_clr) exp_q <= 1'b0;
  end

  // High-byte snapshot taken when the low byte is read, plus the irq level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap  <= 8'd0;
      irq_q <= 1'b0;
    end else begin
      if (rd_en && off == TMR_COUNT_LO) snap <= count[15:8];
      irq_q <= exp_q & ctrl_ie;
    end
  end

  assign irq_o = irq_q;

  // Combinational read mux, zero when not selected.
  always_comb begin
    data_o = 8'h00;
    if (cs_i) begin
      case (off)
        TMR_CTRL:      data_o = {5'b0, ctrl_ie, ctrl_per, ctrl_en};
        TMR_STATUS:    data_o = {6'b0, ctrl_en, exp_q};
        TMR_PRESC_LO:  data_o = presc_div[7:0];
        TMR_PRESC_HI:  data_o = presc_div[15:8];
        TMR_RELOAD_LO: data_o = reload[7:0];
        TMR_RELOAD_HI: data_o = reload[15:8];
        TMR_COUNT_LO:  data_o = count[7:0];
        TMR_COUNT_HI:  data_o = snap;
        default:       data_o = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: reset state, one-shot, periodic irq,
// tear-free count read, count write vs tick, and reset mid-run.
module tb_io_timer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cs_i = 1'b0;
  logic       R_W_n = 1'b1;
  logic [7:0] addr_i = 8'h00;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  io_timer #(.CLK_HZ(27000000)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cs_i   (cs_i),
    .R_W_n  (R_W_n),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .irq_o  (irq_o)
  );

  // Clock: 10 time-unit period.
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    cs_i = 1'b1; R_W_n = 1'b0; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    cs_i = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    cs_i = 1'b1; R_W_n = 1'b1; addr_i = a;
    #1 d = data_o;
    @(posedge clk_i); #1;
    cs_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      bus_read(8'(i) | 8'h08, d);   // upper address bits alias
      check_eq($sformatf("%s_off%0d", tag, i), {8'h00, d}, 16'h0000);
    end
  endtask

  initial begin
    logic [7:0] d, lo, hi;

    // Reset
    idle(3);
    rst_i = 1'b0;
    check_all_zero("reset");
    check_eq("reset_irq", {15'b0, irq_o}, 16'h0000);

    // One-shot: P=0, R=3, CTRL=EN. Expiry 4 clocks after write edge E0.
    bus_write(8'h02, 8'h00); bus_write(8'h03, 8'h00);
    bus_write(8'h04, 8'h03); bus_write(8'h05, 8'h00);
    bus_write(8'h00, 8'h01);                 // edge E0
    idle(3);                                 // after E3
    bus_read(8'h01, d);                      // sampled before E4
    check_eq("oneshot_before_exp", {8'h00, d}, 16'h0002);
    bus_read(8'h01, d);                      // after E4
    check_eq("oneshot_exp_set", {8'h00, d}, 16'h0001);
    bus_read(8'h06, lo); bus_read(8'h07, hi);
    check_eq("oneshot_count", {hi, lo}, 16'h0000);
    idle(4);
    check_eq("oneshot_irq", {15'b0, irq_o}, 16'h0000);

    // Periodic with irq: P=4, R=9, CTRL=0x07, write edge W.
    bus_write(8'h01, 8'h01);
    bus_write(8'h02, 8'h04);
    bus_write(8'h04, 8'h09);
    bus_write(8'h00, 8'h07);                 // edge W
    idle(49);                                // after W+49
    bus_read(8'h01, d);                      // sampled before W+50
    check_eq("per_no_exp_yet", {8'h00, d}, 16'h0002);
    check_eq("per_irq_low", {15'b0, irq_o}, 16'h0000);
    idle(1);                                 // after W+51
    check_eq("per_irq_rise1", {15'b0, irq_o}, 16'h0001);
    bus_write(8'h01, 8'h01);                 // clear at W+52
    idle(1);
    check_eq("per_irq_cleared", {15'b0, irq_o}, 16'h0000);
    idle(46);                                // after W+99
    check_eq("per_irq_low2", {15'b0, irq_o}, 16'h0000);
    idle(2);                                 // after W+101
    check_eq("per_irq_rise2", {15'b0, irq_o}, 16'h0001);
    bus_write(8'h01, 8'h01);                 // clear at W+102
    idle(47);                                // after W+149
    bus_write(8'h01, 8'h01);                 // clear lands on expiry W+150
    bus_read(8'h01, d);
    check_eq("per_set_beats_clear", {8'h00, d}, 16'h0003);

    // Tear-free read: P=0, count loaded to 0x0100 while running.
    bus_write(8'h00, 8'h00);
    bus_write(8'h01, 8'h01);
    bus_write(8'h02, 8'h00);
    bus_write(8'h00, 8'h01);
    bus_write(8'h06, 8'h00);
    bus_write(8'h07, 8'h01);                 // count=0x0100
    idle(1);                                 // count=0x00FF
    bus_read(8'h06, lo);
    idle(1);
    bus_read(8'h07, hi);
    check_eq("tearfree_read", {hi, lo}, 16'h00FF);

    // Count write vs tick: P=4, start at S, ticks at S+5, S+10, ...
    bus_write(8'h00, 8'h00);
    bus_write(8'h02, 8'h04);
    bus_write(8'h04, 8'h50);
    bus_write(8'h00, 8'h01);                 // edge S
    bus_write(8'h06, 8'h34);                 // edge S+1
    idle(3);
    bus_write(8'h07, 8'h12);                 // edge S+5, a tick edge
    bus_read(8'h06, lo);
    bus_read(8'h07, hi);
    check_eq("cntwr_beats_tick", {hi, lo}, 16'h1234);
    bus_write(8'h07, 8'h12);                 // reload at S+8, prescaler cleared
    idle(4);                                 // after S+12
    bus_read(8'h06, lo);                     // sampled before S+13
    check_eq("presc_restart_hold", {8'h00, lo}, 16'h0034);
    bus_read(8'h06, lo);                     // after S+13 tick
    bus_read(8'h07, hi);
    check_eq("presc_restart_tick", {hi, lo}, 16'h1233);

    // Reset mid-run: periodic, P=0, R=2, irq enabled.
    bus_write(8'h00, 8'h00);
    bus_write(8'h02, 8'h00);
    bus_write(8'h04, 8'h02);
    bus_write(8'h00, 8'h07);
    idle(6);
    check_eq("prerst_irq", {15'b0, irq_o}, 16'h0001);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    check_eq("midrst_irq", {15'b0, irq_o}, 16'h0000);
    check_all_zero("midrst");
    idle(20);
    bus_read(8'h01, d);
    check_eq("midrst_no_exp", {8'h00, d}, 16'h0000);
    check_eq("midrst_irq_late", {15'b0, irq_o}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_timer.md
# io_timer

Programmable 16-bit down-counting timer in I/O bank 5 (window $FE00–$FEFF). It is the consumer of `timer_cs` from the address decoder. It provides a 16-bit prescaler, a reload register, one-shot and periodic modes, a sticky expiry flag, a level interrupt, and tear-free 16-bit count reads for the 6502 core.

## Interface
Parameters:
- `CLK_HZ`, 27000000: system clock frequency; informational only, used by software constants.

Ports:
- `clk_i`  in  1  system clock. One clock; all state is on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cs_i`  in  1  select, driven from the decoder `timer_cs`.
- `R_W_n`  in  1  CPU read (1) / write (0).
- `addr_i`  in  8  low byte of the CPU address; register offset.
- `data_i`  in  8  CPU write data.
- `data_o`  out  8  read data. Combinational from `addr_i`; 0 when `cs_i`=0.
- `irq_o`  out  1  interrupt, registered, active-high level.

## Operation
Register map (offset `addr_i[2:0]`; `addr_i[7:3]` is ignored, so the map aliases):
- 0 CTRL, RW: bit0 EN, bit1 PERIODIC, bit2 IE. Bits 7:3 read 0.
- 1 STATUS:
  - bit0 EXP: sticky. Writing 1 clears it; writing 0 has no effect.
  - bit1 RUN: read-only mirror of EN.
- 2/3 PRESC_LO/HI, RW: divider P. One tick every P+1 clocks.
- 4/5 RELOAD_LO/HI, RW: reload value R.
- 6 COUNT_LO:
  - Read returns `count[7:0]` and captures `count[15:8]` into `snap`.
  - Write stages `wr_lo`.
- 7 COUNT_HI:
  - Read returns `snap`.
  - Write loads `count` = {data_i, wr_lo} and clears the prescaler.

Control behaviour:
- An EN transition 0→1 via a CTRL write loads `count` = R and clears the prescaler.
- A CTRL write with EN=1 while already running does not restart the count.
- While EN=1, on each tick:
  - If `count`≠0: `count` decrements by 1.
  - If `count`=0: EXP is set. If PERIODIC, `count` = R; otherwise EN clears and `count` stays 0.
- While EN=0, the prescaler and `count` hold.
- `irq_o` = EXP & IE, registered.

## Timing
- Writes take effect at the clock edge where `cs_i` & ~`R_W_n`.
- Read side-effect (`snap` capture) happens at the edge where `cs_i` & `R_W_n` & offset 6. Repeated edges re-capture, which is harmless because the low byte is returned in the same cycle.
- Tick period is P+1 clocks. P=0 gives a tick every clock.
- Expiry period with PERIODIC set is (R+1)·(P+1) clocks.
- From EN 0→1, the first expiry comes (R+1)·(P+1) clocks after the write edge.
- EXP sets at the edge of the tick that finds `count`=0. `irq_o` follows one cycle later.
- Simultaneous events:
  - EXP set and write-1-clear in the same cycle: set wins.
  - COUNT_HI write or EN-restart in the same cycle as a tick: the write wins and the tick is discarded.
  - CTRL write EN=0 in the same cycle as an expiry: EXP still sets, and EN ends at 0.
- Counter arithmetic is 16-bit unsigned and never underflows; 0 is the terminal value.
- Reset clears every register: CTRL, EXP, P, R, `count`, `wr_lo`, `snap`, and the prescaler are 0, and `irq_o`=0.
- Reset mid-count abandons the count. Nothing is preserved.

## Structure
- Package `io_timer_pkg`:
  - Register offset localparams (`TMR_CTRL`…`TMR_COUNT_HI`).
  - CTRL/STATUS bit positions.
  - The IO bank number (8'h05), which is shared with the address decoder.
- One sub-module, `timer_prescaler`:
  - 16-bit counter.
  - Inputs: `en`, `clr`, `div[15:0]`.
  - Output: one-cycle `tick` when the counter equals `div`, then wraps to 0.
- The top level holds the register file, the down-counter, and the read mux.

## Test plan
- Reset: after reset, reading every offset returns 00 and `irq_o`=0.
- One-shot:
  - Stimulus: P=0, R=3, CTRL=0x01.
  - Expected: EXP sets exactly 4 clocks after the write edge; RUN reads 0; COUNT reads 0000; `irq_o` stays 0 because IE=0.
- Periodic with interrupt:
  - Stimulus: P=4, R=9, CTRL=0x07.
  - Expected: `irq_o` rises every 50 clocks once EXP is cleared by a STATUS write of 0x01. A clear write landing on the expiry edge leaves EXP=1.
- Tear-free read:
  - Stimulus: COUNT preloaded to 0x0100, running with P=0.
  - Expected: reading offset 6 then offset 7 two cycles later yields 0x00FF (low byte at capture, high byte from `snap`=0x00), never 0x01FF.
- Count write vs. tick:
  - Stimulus: COUNT_LO=0x34, then COUNT_HI=0x12 on a tick edge.
  - Expected: the next read is 0x1234 and the prescaler restarts from 0.
- Reset mid-run:
  - Stimulus: assert `rst_i` for 1 cycle while periodic and running.
  - Expected: all registers are 0, no further expiry occurs, and `irq_o`=0 on the following cycle.
